cache_fill_wb_ctrl: RTL and testbench

Parametrised miss-handling controller for the L1 caches: the successor to the fixed 8-word, 16-bit fill FSM. It generalises address width, word size and block depth. It adds a request handshake toward memory (mem_ready) and an optional dirty-victim write-back phase ahead of the block fill. It sits between the tag-match logic and the multi-cycle main memory, and fsm_busy drives the pipeline stall.

---
 rtl/cache_fill_wb_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cache_fill_wb_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_wb_ctrl.sv
// Miss-handling controller for the L1 caches: optional dirty-victim write-back,
// then a block fill with independent request/return counters, then a tag write.
module cache_fill_wb_ctrl #(
   parameter int ADDR_W      = 16,
   parameter int WORD_BYTES  = 2,
   parameter int BLOCK_WORDS = 8,
   parameter int WRITE_BACK  = 1,
   localparam int OFF_W      = $clog2(BLOCK_WORDS * WORD_BYTES),
   localparam int DATA_W     = 8 * WORD_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_addr,
   input  logic              victim_dirty,
   input  logic [ADDR_W-1:0] victim_addr,
   input  logic [DATA_W-1:0] victim_data,
   input  logic              mem_ready,
   input  logic              memory_data_valid,
   output logic              fsm_busy,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [OFF_W-1:0]  cache_rd_offset,
   output logic              write_data_array,
   output logic [OFF_W-1:0]  cache_write_block_offset,
   output logic              write_tag_array,
   output logic [ADDR_W-1:0] base_addr
);

   localparam int SHIFT = $clog2(WORD_BYTES);
   localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(BLOCK_WORDS);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [OFF_W-1:0]  OFF_STEP   = OFF_W'(WORD_BYTES);
   localparam logic [OFF_W-1:0]  OFF_LAST   = OFF_W'((BLOCK_WORDS - 1) * WORD_BYTES);
   localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((1 << OFF_W) - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] victim_base;
   logic [OFF_W-1:0]  wb_off;
   logic [CNT_W-1:0]  rd_cnt;
   logic [CNT_W-1:0]  wr_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (miss_detected) begin
               state_next = ((WRITE_BACK != 0) && victim_dirty) ? WB : FILL;
            end
         end
         WB: begin
            if (mem_ready && (wb_off == OFF_LAST)) begin
               state_next = FILL;
            end
         end
         FILL: begin
            // Leave only once every returned word has landped in the array.
            if (wr_cnt == CNT_FULL) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fsm_busy                 = 1'b0;
      mem_read                 = 1'b0;
      mem_write                = 1'b0;
      mem_addr                 = '0;
      mem_wdata                = '0;
      cache_rd_offset          = '0;
      write_data_array         = 1'b0;
      cache_write_block_offset = '0;
      write_tag_array          = 1'b0;
      unique case (state)
         WB: begin
            fsm_busy        = 1'b1;
            mem_write       = 1'b1;
            mem_addr        = victim_base + ADDR_W'(wb_off);
            cache_rd_offset = wb_off;
            mem_wdata       = victim_data;
         end
         FILL: begin
            fsm_busy         = 1'b1;
            mem_read         = (rd_cnt < CNT_FULL);
            if (mem_read) begin
               mem_addr = base_addr + (ADDR_W'(rd_cnt) << SHIFT);
            end
            write_data_array = memory_data_valid && (wr_cnt < CNT_FULL);
            if (write_data_array) begin
               cache_write_block_offset = OFF_W'(32'(wr_cnt) << SHIFT);
            end
         end
         DONE: begin
            fsm_busy        = 1'b1;
            write_tag_array = 1'b1;
         end
         default: ;
      endcase
   end

   // Request and return counters advance independently; both clear on DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_addr   <= '0;
         victim_base <= '0;
         wb_off      <= '0;
         rd_cnt      <= '0;
         wr_cnt      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (miss_detected) begin
                  base_addr   <= miss_addr & BLOCK_MASK;
                  victim_base <= victim_addr & BLOCK_MASK;
                  wb_off      <= '0;
                  rd_cnt      <= '0;
                  wr_cnt      <= '0;
               end
            end
            WB: begin
               if (mem_ready) begin
                  wb_off <= wb_off + OFF_STEP;
               end
            end
            FILL: begin
               if (mem_read && mem_ready) begin
                  rd_cnt <= rd_cnt + CNT_ONE;
               end
               if (write_data_array) begin
                  wr_cnt <= wr_cnt + CNT_ONE;
               end
            end
            DONE: begin
               base_addr   <= '0;
               victim_base <= '0;
               wb_off      <= '0;
               rd_cnt      <= '0;
               wr_cnt      <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_fill_wb_ctrl.sv
// Scoreboard bench for cache_fill_wb_ctrl: a default write-back instance and a
// 4-word write-through instance, with a small in-order memory responder.
module tb_cache_fill_wb_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        miss_a, miss_b;
   logic [15:0] miss_addr;
   logic        victim_dirty;
   logic [15:0] victim_addr;
   logic [15:0] victim_data;
   logic        mem_ready;
   logic        memory_data_valid;

   logic        busy_a, read_a, write_a, wda_a, tag_a;
   logic [15:0] addr_a, wdata_a, base_a;
   logic [3:0]  rdoff_a, wroff_a;
   logic        busy_b, read_b, write_b, wda_b, tag_b;
   logic [15:0] addr_b, wdata_b, base_b;
   logic [2:0]  rdoff_b, wroff_b;

   logic        sel;
   logic        m_busy, m_read, m_write, m_wda, m_tag;
   logic [15:0] m_addr, m_wdata, m_base;
   logic [3:0]  m_rdoff, m_off;

   logic        ready_alt, gap_mode, inject_valid;
   logic        acc, vld_prev;
   int          pending, cyc;

   int          tests = 0;
   int          fails = 0;
   int          fill_seen = 0;
   int          tag_seen = 0;

   logic [15:0] exp_rd_q[$];
   logic [31:0] exp_wr_q[$];
   logic [3:0]  exp_off_q[$];
   logic [15:0] exp_tag_q[$];

   cache_fill_wb_ctrl dut_a (
      .clk(clk), .rst(rst), .miss_detected(miss_a), .miss_addr(miss_addr),
      .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
      .mem_ready(mem_ready), .memory_data_valid(memory_data_valid),
      .fsm_busy(busy_a), .mem_read(read_a), .mem_write(write_a), .mem_addr(addr_a),
      .mem_wdata(wdata_a), .cache_rd_offset(rdoff_a), .write_data_array(wda_a),
      .cache_write_block_offset(wroff_a), .write_tag_array(tag_a), .base_addr(base_a)
   );

   cache_fill_wb_ctrl #(.WRITE_BACK(0), .BLOCK_WORDS(4)) dut_b (
      .clk(clk), .rst(rst), .miss_detected(miss_b), .miss_addr(miss_addr),
      .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
      .mem_ready(mem_ready), .memory_data_valid(memory_data_valid),
      .fsm_busy(busy_b), .mem_read(read_b), .mem_write(write_b), .mem_addr(addr_b),
      .mem_wdata(wdata_b), .cache_rd_offset(rdoff_b), .write_data_array(wda_b),
      .cache_write_block_offset(wroff_b), .write_tag_array(tag_b), .base_addr(base_b)
   );

   // Data-array model: each victim word carries its own byte offset.
   assign victim_data = 16'hD000 | {12'h000, rdoff_a};

   always_comb begin
      if (sel) begin
         m_busy = busy_b; m_read = read_b; m_write = write_b; m_wda = wda_b; m_tag = tag_b;
         m_addr = addr_b; m_wdata = wdata_b; m_base = base_b;
         m_rdoff = {1'b0, rdoff_b}; m_off = {1'b0, wroff_b};
      end else begin
         m_busy = busy_a; m_read = read_a; m_write = write_a; m_wda = wda_a; m_tag = tag_a;
         m_addr = addr_a; m_wdata = wdata_a; m_base = base_a;
         m_rdoff = rdoff_a; m_off = wroff_a;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pushFill(input logic [15:0] base, input int words);
      for (int k = 0; k < words; k++) begin
         exp_rd_q.push_back(base + 16'(2 * k));
         exp_off_q.push_back(4'(2 * k));
      end
      exp_tag_q.push_back(base);
   endtask

   task automatic pushWb(input logic [15:0] vbase, input int words);
      for (int k = 0; k < words; k++) begin
         exp_wr_q.push_back({vbase + 16'(2 * k), 16'hD000 + 16'(2 * k)});
      end
   endtask

   task automatic checkDrained(input string tag);
      checkOutput({tag, "_reads_left"}, 32'(exp_rd_q.size()), 32'd0);
      checkOutput({tag, "_writes_left"}, 32'(exp_wr_q.size()), 32'd0);
      checkOutput({tag, "_fills_left"}, 32'(exp_off_q.size()), 32'd0);
      checkOutput({tag, "_tags_left"}, 32'(exp_tag_q.size()), 32'd0);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_busy"}, 32'(m_busy), 32'd0);
      checkOutput({tag, "_read"}, 32'(m_read), 32'd0);
      checkOutput({tag, "_write"}, 32'(m_write), 32'd0);
      checkOutput({tag, "_addr"}, 32'(m_addr), 32'd0);
      checkOutput({tag, "_wdata"}, 32'(m_wdata), 32'd0);
      checkOutput({tag, "_rdoff"}, 32'(m_rdoff), 32'd0);
      checkOutput({tag, "_wda"}, 32'(m_wda), 32'd0);
      checkOutput({tag, "_wroff"}, 32'(m_off), 32'd0);
      checkOutput({tag, "_tag"}, 32'(m_tag), 32'd0);
      checkOutput({tag, "_base"}, 32'(m_base), 32'd0);
   endtask

   task automatic applyStimulus(input logic [15:0] addr, input logic dirty,
                                input logic [15:0] vaddr, input bit hold, output int busy);
      bit done;
      @(negedge clk);
      miss_addr    = addr;
      victim_dirty = dirty;
      victim_addr  = vaddr;
      if (sel) miss_b = 1'b1;
      else     miss_a = 1'b1;
      busy = 0;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (!hold) begin
            miss_a = 1'b0;
            miss_b = 1'b0;
         end
         if (m_busy) busy++;
         else if (busy > 0) done = 1'b1;
         if (hold && m_tag) begin
            miss_a = 1'b0;
            miss_b = 1'b0;
         end
      end
      miss_a = 1'b0;
      miss_b = 1'b0;
      checkOutput("miss_completed", 32'(done), 32'd1);
   endtask

   // In-order memory: one return per accepted read, optionally with gaps.
   initial begin
      mem_ready = 1'b1;
      memory_data_valid = 1'b0;
      pending = 0;
      cyc = 0;
      forever begin
         @(negedge clk);
         acc      = m_read && mem_ready;
         vld_prev = memory_data_valid;
         @(posedge clk);
         #1;
         cyc++;
         if (rst) begin
            pending = 0;
         end else begin
            if (vld_prev && pending > 0) pending--;
            if (acc) pending++;
         end
         mem_ready = ready_alt ? (cyc % 2 == 1) : 1'b1;
         memory_data_valid = inject_valid || (pending > 0 && (!gap_mode || (cyc % 3) != 2));
      end
   end

   // Monitor: pops the scoreboard whenever the active instance presents an event.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (m_write && mem_ready) begin
               checkOutput("read_during_wb", 32'(m_read), 32'd0);
               checkOutput("wb_expected", 32'(exp_wr_q.size() != 0), 32'd1);
               if (exp_wr_q.size() != 0) begin
                  e = exp_wr_q.pop_front();
                  checkOutput("wb_addr", 32'(m_addr), 32'(e[31:16]));
                  checkOutput("wb_data", 32'(m_wdata), 32'(e[15:0]));
               end
            end
            if (m_read && mem_ready) begin
               checkOutput("read_expected", 32'(exp_rd_q.size() != 0), 32'd1);
               if (exp_rd_q.size() != 0) checkOutput("read_addr", 32'(m_addr), 32'(exp_rd_q.pop_front()));
            end
            if (m_wda) begin
               fill_seen++;
               checkOutput("fill_expected", 32'(exp_off_q.size() != 0), 32'd1);
               if (exp_off_q.size() != 0) checkOutput("fill_offset", 32'(m_off), 32'(exp_off_q.pop_front()));
            end
            if (m_tag) begin
               tag_seen++;
               checkOutput("tag_expected", 32'(exp_tag_q.size() != 0), 32'd1);
               if (exp_tag_q.size() != 0) checkOutput("tag_base", 32'(m_base), 32'(exp_tag_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int busy;
      int f0;
      rst = 1'b1; miss_a = 1'b0; miss_b = 1'b0; sel = 1'b0;
      miss_addr = '0; victim_dirty = 1'b0; victim_addr = '0;
      ready_alt = 1'b0; gap_mode = 1'b0; inject_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkIdle("reset");
      rst = 1'b0;
      @(negedge clk);

      // Clean miss, back-to-back memory.
      pushFill(16'h1230, 8);
      applyStimulus(16'h1236, 1'b0, 16'h0000, 1'b0, busy);
      checkOutput("t1_busy_cycles", 32'(busy), 32'd11);
      repeat (3) @(negedge clk);
      checkDrained("t1");

      // Dirty victim written back before the fill.
      pushWb(16'h04A0, 8);
      pushFill(16'h0810, 8);
      applyStimulus(16'h0810, 1'b1, 16'h04A0, 1'b0, busy);
      checkOutput("t2_busy_cycles", 32'(busy), 32'd19);
      repeat (3) @(negedge clk);
      checkDrained("t2");

      // Stalling memory and gapped returns.
      ready_alt = 1'b1;
      gap_mode  = 1'b1;
      pushWb(16'h7700, 8);
      pushFill(16'h2340, 8);
      applyStimulus(16'h2345, 1'b1, 16'h7700, 1'b0, busy);
      repeat (4) @(negedge clk);
      checkDrained("t3");
      ready_alt = 1'b0;
      gap_mode  = 1'b0;
      repeat (3) @(negedge clk);

      // Reset in the middle of a fill, stray return, then a clean restart.
      pushFill(16'h3000, 8);
      f0 = fill_seen;
      miss_addr = 16'h3004; victim_dirty = 1'b0; miss_a = 1'b1;
      @(negedge clk);
      miss_a = 1'b0;
      for (int i = 0; i < 100 && (fill_seen - f0) < 3; i++) @(posedge clk);
      checkOutput("t4_three_words", 32'((fill_seen - f0) >= 3), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkIdle("t4_after_rst");
      exp_rd_q.delete(); exp_wr_q.delete(); exp_off_q.delete(); exp_tag_q.delete();
      f0 = fill_seen;
      inject_valid = 1'b1;
      @(negedge clk);
      inject_valid = 1'b0;
      checkOutput("t4_stray_valid_seen", 32'(memory_data_valid), 32'd1);
      checkOutput("t4_stray_valid_wda", 32'(m_wda), 32'd0);
      @(negedge clk);
      checkOutput("t4_stray_no_fill", 32'(fill_seen - f0), 32'd0);
      pushFill(16'h3000, 8);
      applyStimulus(16'h3004, 1'b0, 16'h0000, 1'b0, busy);
      checkOutput("t4_restart_busy", 32'(busy), 32'd11);
      repeat (3) @(negedge clk);
      checkDrained("t4");

      // Stray return in IDLE, then miss held high for the whole fill.
      f0 = fill_seen;
      inject_valid = 1'b1;
      @(negedge clk);
      inject_valid = 1'b0;
      checkOutput("t5_idle_valid_wda", 32'(m_wda), 32'd0);
      @(negedge clk);
      f0 = tag_seen;
      pushFill(16'h5670, 8);
      applyStimulus(16'h5678, 1'b0, 16'h0000, 1'b1, busy);
      checkOutput("t5_busy_cycles", 32'(busy), 32'd11);
      repeat (4) @(negedge clk);
      checkOutput("t5_single_tag", 32'(tag_seen - f0), 32'd1);
      checkOutput("t5_stays_idle", 32'(m_busy), 32'd0);
      checkDrained("t5");

      // Write-through, 4-word block: dirty victim must be ignored.
      sel = 1'b1;
      @(negedge clk);
      pushFill(16'h00F8, 4);
      applyStimulus(16'h00FF, 1'b1, 16'h0040, 1'b0, busy);
      checkOutput("t6_busy_cycles", 32'(busy), 32'd7);
      repeat (3) @(negedge clk);
      checkDrained("t6");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
